// File: rtl/mseq_pkg.sv
// Shared m-sequence definitions used by the transmit generator and by the receive correlator.
package mseq_pkg;

    localparam int          MSEQ_N    = 7;
    localparam logic [31:0] MSEQ_POLY = 32'b1100000;
    localparam logic [31:0] MSEQ_SEED = 32'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // One Fibonacci step on a zero-extended state; the caller keeps the low N bits.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] poly);
        return {state[30:0], ^(state & poly)};
    endfunction

endpackage

// File: rtl/mseq_lfsr.sv
// Local code generator: a phase-start register and a running LFSR that either steps,
// reloads from the seed, or slips to the next code phase.
module mseq_lfsr
    import mseq_pkg::*;
#(
    parameter int           N    = MSEQ_N,
    parameter logic [N-1:0] POLY = N'(MSEQ_POLY),
    parameter logic [N-1:0] SEED = N'(MSEQ_SEED)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic step,
    input  logic slip,
    output logic chip
);

    logic [N-1:0] phase_start;
    logic [N-1:0] lfsr;
    logic [N-1:0] start_adv;
    logic [N-1:0] lfsr_adv;

    always_comb begin
        start_adv = N'(lfsr_next(32'(phase_start), 32'(POLY)));
        lfsr_adv  = N'(lfsr_next(32'(lfsr), 32'(POLY)));
    end

    // A slip restarts the running copy one chip later than the previous phase began.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_start <= SEED;
            lfsr        <= SEED;
        end else if (load) begin
            phase_start <= SEED;
            lfsr        <= SEED;
        end else if (slip) begin
            phase_start <= start_adv;
            lfsr        <= start_adv;
        end else if (step) begin
            lfsr        <= lfsr_adv;
        end
    end

    assign chip = lfsr[N-1];

endmodule

// File: rtl/mseq_corr_search.sv
// Serial code-phase search: correlates L samples per phase against the local m-sequence
// over all L phases and keeps the largest-magnitude result. Debug stream: MSEQ_CORR_DBG_EN.
module mseq_corr_search
    import mseq_pkg::*;
#(
    parameter int           N            = MSEQ_N,
    parameter logic [N-1:0] POLY         = N'(MSEQ_POLY),
    parameter logic [N-1:0] SEED         = N'(MSEQ_SEED),
    parameter int           SAMPLE_WIDTH = 32,
    parameter int           ACC_WIDTH    = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    output logic                    busy,
    output logic                    done,
    output logic [N-1:0]            peak_phase,
    output logic [ACC_WIDTH-1:0]    peak_value
`ifdef MSEQ_CORR_DBG_EN
    ,
    output logic                    corr_valid,
    output logic [ACC_WIDTH-1:0]    corr_value
`endif
);

    localparam int           L    = (1 << N) - 1;
    localparam logic [N-1:0] LAST = N'(L - 1);

    state_t                      state;
    state_t                      state_nxt;
    logic [N-1:0]                samp_cnt;
    logic [N-1:0]                phase_cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] sample_ext;
    logic signed [ACC_WIDTH-1:0] term;
    logic                        chip;
    logic                        fire;
    logic                        take;
    logic                        phase_end;
    logic                        last_end;
    logic                        better;
    logic                        done_q;
    logic                        lfsr_load;
    logic                        lfsr_step;
    logic                        lfsr_slip;

    function automatic logic [ACC_WIDTH-1:0] abs_val(input logic signed [ACC_WIDTH-1:0] v);
        return v[ACC_WIDTH-1] ? ACC_WIDTH'(-v) : ACC_WIDTH'(v);
    endfunction

    assign fire      = start && (state != SEARCH);
    assign take      = (state == SEARCH) && sample_valid;
    assign phase_end = take && (samp_cnt == LAST);
    assign last_end  = phase_end && (phase_cnt == LAST);

    always_comb begin
        sample_ext = {{(ACC_WIDTH - SAMPLE_WIDTH){sample_in[SAMPLE_WIDTH-1]}}, sample_in};
        term       = chip ? sample_ext : -sample_ext;
        acc_next   = acc + term;
        // Strict compare so the earliest phase keeps a tie; phase 0 always seeds the peak.
        better     = (phase_cnt == '0) || (abs_val(acc_next) > abs_val(peak_value));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = SEARCH;
            SEARCH:  if (last_end) state_nxt = DONE;
            DONE:    if (start)    state_nxt = SEARCH;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == SEARCH);
        done      = done_q;
        lfsr_load = fire;
        lfsr_step = take && !phase_end;
        lfsr_slip = phase_end;
    end

    mseq_lfsr #(
        .N    (N),
        .POLY (POLY),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .slip  (lfsr_slip),
        .chip  (chip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            samp_cnt   <= '0;
            phase_cnt  <= '0;
            peak_phase <= '0;
            peak_value <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= last_end;
            if (fire) begin
                acc       <= '0;
                samp_cnt  <= '0;
                phase_cnt <= '0;
            end else if (phase_end) begin
                acc       <= '0;
                samp_cnt  <= '0;
                phase_cnt <= phase_cnt + 1'b1;
                if (better) begin
                    peak_value <= acc_next;
                    peak_phase <= phase_cnt;
                end
            end else if (take) begin
                acc      <= acc_next;
                samp_cnt <= samp_cnt + 1'b1;
            end
        end
    end

`ifdef MSEQ_CORR_DBG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_valid <= 1'b0;
            corr_value <= '0;
        end else begin
            corr_valid <= phase_end;
            if (phase_end) corr_value <= acc_next;
        end
    end
`endif

endmodule

// File: tb/tb_mseq_corr_search.sv
// Randomized bench for mseq_corr_search against a direct correlation model of the search.
`timescale 1ns/1ps
module tb_mseq_corr_search;
    localparam int N     = 7;
    localparam int L     = 127;
    localparam int SW    = 32;
    localparam int AW    = 40;
    localparam int TOTAL = L * L;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] sample_in = '0;
    logic          busy;
    logic          done;
    logic [N-1:0]  peak_phase;
    logic [AW-1:0] peak_value;
`ifdef MSEQ_CORR_DBG_EN
    logic          corr_valid;
    logic [AW-1:0] corr_value;
`endif

    int            n_cmp = 0;
    int            n_bad = 0;
    int            seq[L];
    int            xs[TOTAL];
    longint        corr[L];
    logic [AW-1:0] exp_q[$];
    int            done_cnt = 0;
    int            corr_cnt = 0;
    int            exp_phase;
    longint        exp_value;

    always #5 clk = ~clk;

    mseq_corr_search dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .busy         (busy),
        .done         (done),
        .peak_phase   (peak_phase),
        .peak_value   (peak_value)
`ifdef MSEQ_CORR_DBG_EN
        ,
        .corr_valid   (corr_valid),
        .corr_value   (corr_value)
`endif
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference sequence: chip i is the MSB of the state after i steps from seed 1.
    function automatic void build_seq();
        int s = 1;
        for (int i = 0; i < L; i++) begin
            seq[i] = (s >> 6) & 1;
            s = ((s << 1) | (((s >> 6) ^ (s >> 5)) & 1)) & 127;
        end
    endfunction

    function automatic void make_stream(input int d, input int amp);
        for (int j = 0; j < TOTAL; j++)
            xs[j] = (seq[(j + d) % L] == 1) ? amp : -amp;
    endfunction

    // Phase k correlates samples k*L..k*L+L-1 with the sequence started k chips late.
    function automatic void model();
        exp_q.delete();
        for (int k = 0; k < L; k++) begin
            longint sum = 0;
            for (int i = 0; i < L; i++)
                sum += (seq[(k + i) % L] == 1) ? longint'(xs[k * L + i]) : -longint'(xs[k * L + i]);
            corr[k] = sum;
            exp_q.push_back(AW'(sum));
        end
        exp_phase = 0;
        exp_value = corr[0];
        for (int k = 1; k < L; k++)
            if (labs(corr[k]) > labs(exp_value)) begin
                exp_phase = k;
                exp_value = corr[k];
            end
    endfunction

    always @(negedge clk) begin
        if (done) done_cnt++;
`ifdef MSEQ_CORR_DBG_EN
        if (corr_valid) begin
            corr_cnt++;
            if (exp_q.size() == 0) check("corr_extra", 1, 0);
            else check("corr_value", longint'($signed(corr_value)), longint'($signed(exp_q.pop_front())));
        end
`endif
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_peak_phase"}, longint'(peak_phase), 0);
        check({tag, "_peak_value"}, longint'($signed(peak_value)), 0);
`ifdef MSEQ_CORR_DBG_EN
        check({tag, "_corr_valid"}, longint'(corr_valid), 0);
        check({tag, "_corr_value"}, longint'($signed(corr_value)), 0);
`endif
    endtask

    task automatic run_search(input string tag, input bit gaps, input int mid_start_at, input int abort_at);
        done_cnt = 0;
        corr_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_start"}, longint'(busy), 1);
        for (int j = 0; j < TOTAL; j++) begin
            if (j == abort_at) begin
                int     pp = 0;
                longint pv = corr[0];
                for (int k = 1; k < j / L; k++)
                    if (labs(corr[k]) > labs(pv)) begin
                        pp = k;
                        pv = corr[k];
                    end
                check({tag, "_part_phase"}, longint'(peak_phase), pp);
                check({tag, "_part_value"}, longint'($signed(peak_value)), pv);
                rst_n = 1'b0;
                #1;
                check_reset_outputs({tag, "_async"});
                exp_q.delete();
                sample_valid = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (gaps)
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
                    sample_valid = 1'b0;
                    sample_in = SW'($urandom);
                    @(posedge clk); #1;
                end
            if (j == TOTAL - 1) check({tag, "_done_early"}, longint'(done_cnt) + longint'(done), 0);
            sample_valid = 1'b1;
            sample_in = SW'(xs[j]);
            start = (j == mid_start_at);
            @(posedge clk); #1;
            start = 1'b0;
            if (j == mid_start_at) check({tag, "_busy_after_restart"}, longint'(busy), 1);
        end
        sample_valid = 1'b0;
        check({tag, "_done"}, longint'(done), 1);
        check({tag, "_busy_end"}, longint'(busy), 0);
        check({tag, "_peak_phase"}, longint'(peak_phase), exp_phase);
        check({tag, "_peak_value"}, longint'($signed(peak_value)), exp_value);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, longint'(done), 0);
        repeat (5) begin
            sample_valid = 1'b1;
            sample_in = SW'($urandom);
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        check({tag, "_done_count"}, longint'(done_cnt), 1);
        check({tag, "_hold_phase"}, longint'(peak_phase), exp_phase);
        check({tag, "_hold_value"}, longint'($signed(peak_value)), exp_value);
`ifdef MSEQ_CORR_DBG_EN
        check({tag, "_corr_count"}, longint'(corr_cnt), L);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        build_seq();

        make_stream(45, 1000);
        model();
        run_search("d45_gaps", 1'b1, 5000, -1);

        make_stream(10, -1000);
        model();
        run_search("inv_d10", 1'b0, -1, -1);

        make_stream(0, 0);
        model();
        run_search("zero", 1'b0, -1, -1);

        make_stream(45, 1000);
        model();
        run_search("rst_mid", 1'b0, -1, 31 * L + 20);
        model();
        run_search("restart_d45", 1'b0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
